// File: rtl/midi_poly_voice_allocator_pkg.sv
// Shared MIDI constants and types for the polyphonic voice allocator.
// Status nibbles, controller numbers, parser states and decoded message kinds.
package midi_poly_voice_allocator_pkg;

   localparam logic [3:0] ST_NOTE_OFF = 4'h8;
   localparam logic [3:0] ST_NOTE_ON  = 4'h9;
   localparam logic [3:0] ST_CC       = 4'hB;
   localparam logic [3:0] ST_PROGRAM  = 4'hC;
   localparam logic [3:0] ST_CHAN_AT  = 4'hD;

   localparam logic [6:0] CC_SUSTAIN       = 7'd64;
   localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
   localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

   localparam logic [7:0] SYS_FIRST = 8'hF0;
   localparam logic [7:0] RT_FIRST  = 8'hF8;

   typedef enum logic [1:0] {
      PS_IDLE,
      PS_DATA1,
      PS_DATA2,
      PS_SKIP
   } parser_state_e;

   typedef enum logic [1:0] {
      MSG_NOTE_OFF,
      MSG_NOTE_ON,
      MSG_CC
   } msg_type_e;

   // Program change and channel pressure carry a single data byte.
   function automatic logic single_data_byte(input logic [3:0] nibble);
      return (nibble == ST_PROGRAM) || (nibble == ST_CHAN_AT);
   endfunction

endpackage

// File: rtl/midi_poly_voice_allocator_parser.sv
// MIDI byte-stream parser with running status and channel filtering.
// Emits a registered one-cycle msg_valid for note off/on and control change.
module midi_msg_parser
   import midi_poly_voice_allocator_pkg::*;
#(
   parameter bit OMNI = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   input  logic [3:0] midi_channel,
   output logic       msg_valid,
   output msg_type_e  msg_type,
   output logic [6:0] msg_note,
   output logic [6:0] msg_value
);

   parser_state_e state_q, state_d;
   logic [3:0]    status_q, status_d;
   logic          match_q, match_d;
   logic [6:0]    data1_q, data1_d;
   logic          msg_valid_q, msg_valid_d;
   msg_type_e     msg_type_q, msg_type_d;
   logic [6:0]    msg_note_q, msg_note_d;
   logic [6:0]    msg_value_q, msg_value_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PS_IDLE;
         status_q    <= '0;
         match_q     <= 1'b0;
         data1_q     <= '0;
         msg_valid_q <= 1'b0;
         msg_type_q  <= MSG_NOTE_OFF;
         msg_note_q  <= '0;
         msg_value_q <= '0;
      end else begin
         state_q     <= state_d;
         status_q    <= status_d;
         match_q     <= match_d;
         data1_q     <= data1_d;
         msg_valid_q <= msg_valid_d;
         msg_type_q  <= msg_type_d;
         msg_note_q  <= msg_note_d;
         msg_value_q <= msg_value_d;
      end
   end

   // Real-time bytes fall through untouched so they may interleave with any message.
   always_comb begin
      state_d     = state_q;
      status_d    = status_q;
      match_d     = match_q;
      data1_d     = data1_q;
      msg_valid_d = 1'b0;
      msg_type_d  = msg_type_q;
      msg_note_d  = msg_note_q;
      msg_value_d = msg_value_q;
      if (rx_valid && (rx_byte < RT_FIRST)) begin
         if (rx_byte >= SYS_FIRST) begin
            state_d = PS_SKIP;
         end else if (rx_byte[7]) begin
            status_d = rx_byte[7:4];
            match_d  = OMNI | (rx_byte[3:0] == midi_channel);
            state_d  = PS_DATA1;
         end else begin
            case (state_q)
               PS_DATA1: begin
                  if (!single_data_byte(status_q)) begin
                     data1_d = rx_byte[6:0];
                     state_d = PS_DATA2;
                  end
               end
               PS_DATA2: begin
                  state_d     = PS_DATA1;
                  msg_note_d  = data1_q;
                  msg_value_d = rx_byte[6:0];
                  if (match_q) begin
                     case (status_q)
                        ST_NOTE_OFF: begin
                           msg_valid_d = 1'b1;
                           msg_type_d  = MSG_NOTE_OFF;
                        end
                        ST_NOTE_ON: begin
                           msg_valid_d = 1'b1;
                           msg_type_d  = (rx_byte[6:0] == 7'd0) ? MSG_NOTE_OFF : MSG_NOTE_ON;
                        end
                        ST_CC: begin
                           msg_valid_d = 1'b1;
                           msg_type_d  = MSG_CC;
                        end
                        default: ;
                     endcase
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign msg_valid = msg_valid_q;
   assign msg_type  = msg_type_q;
   assign msg_note  = msg_note_q;
   assign msg_value = msg_value_q;

endmodule

// File: rtl/midi_poly_voice_allocator.sv
// Polyphonic MIDI voice allocator: parses the byte stream and maps notes onto
// NUM_VOICES slots with sustain pedal handling and oldest-voice stealing.
module midi_poly_voice_allocator
   import midi_poly_voice_allocator_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter bit OMNI       = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_byte,
   input  logic [3:0]              midi_channel,
   output logic [7*NUM_VOICES-1:0] voice_note,
   output logic [7*NUM_VOICES-1:0] voice_velocity,
   output logic [NUM_VOICES-1:0]   voice_gate,
   output logic [NUM_VOICES-1:0]   voice_trigger
);

   localparam int RW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [RW-1:0] OLDEST = RW'(NUM_VOICES - 1);

   logic       msg_valid;
   msg_type_e  msg_type;
   logic [6:0] msg_note;
   logic [6:0] msg_value;

   midi_msg_parser #(
      .OMNI(OMNI)
   ) u_parser (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_valid    (rx_valid),
      .rx_byte     (rx_byte),
      .midi_channel(midi_channel),
      .msg_valid   (msg_valid),
      .msg_type    (msg_type),
      .msg_note    (msg_note),
      .msg_value   (msg_value)
   );

   logic [6:0]            note_q [NUM_VOICES];
   logic [6:0]            note_d [NUM_VOICES];
   logic [6:0]            vel_q  [NUM_VOICES];
   logic [6:0]            vel_d  [NUM_VOICES];
   logic [RW-1:0]         rank_q [NUM_VOICES];
   logic [RW-1:0]         rank_d [NUM_VOICES];
   logic [NUM_VOICES-1:0] gate_q, gate_d;
   logic [NUM_VOICES-1:0] sus_q, sus_d;
   logic [NUM_VOICES-1:0] trig_q, trig_d;
   logic                  sustain_q, sustain_d;

   logic          hit_found, free_found;
   logic [RW-1:0] hit_idx, free_idx, old_idx, alloc_idx, alloc_rank;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            note_q[i] <= '0;
            vel_q[i]  <= '0;
            rank_q[i] <= RW'(NUM_VOICES - 1 - i);
         end
         gate_q    <= '0;
         sus_q     <= '0;
         trig_q    <= '0;
         sustain_q <= 1'b0;
      end else begin
         note_q    <= note_d;
         vel_q     <= vel_d;
         rank_q    <= rank_d;
         gate_q    <= gate_d;
         sus_q     <= sus_d;
         trig_q    <= trig_d;
         sustain_q <= sustain_d;
      end
   end

   // Priority: a gated voice already on this note, then lowest free voice, then the oldest.
   always_comb begin
      hit_found  = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      old_idx    = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (gate_q[i] && (note_q[i] == msg_note)) begin
            hit_found = 1'b1;
            hit_idx   = RW'(i);
         end
         if (!gate_q[i]) begin
            free_found = 1'b1;
            free_idx   = RW'(i);
         end
         if (rank_q[i] == OLDEST) begin
            old_idx = RW'(i);
         end
      end
      alloc_idx = hit_found ? hit_idx : (free_found ? free_idx : old_idx);
      alloc_rank = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (RW'(i) == alloc_idx) begin
            alloc_rank = rank_q[i];
         end
      end
   end

   always_comb begin
      note_d    = note_q;
      vel_d     = vel_q;
      rank_d    = rank_q;
      gate_d    = gate_q;
      sus_d     = sus_q;
      trig_d    = '0;
      sustain_d = sustain_q;
      if (msg_valid) begin
         case (msg_type)
            MSG_NOTE_ON: begin
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (RW'(i) == alloc_idx) begin
                     note_d[i] = msg_note;
                     vel_d[i]  = msg_value;
                     gate_d[i] = 1'b1;
                     sus_d[i]  = 1'b0;
                     trig_d[i] = 1'b1;
                     rank_d[i] = '0;
                  end else if (rank_q[i] < alloc_rank) begin
                     rank_d[i] = rank_q[i] + 1'b1;
                  end
               end
            end
            MSG_NOTE_OFF: begin
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (gate_q[i] && (note_q[i] == msg_note)) begin
                     if (sustain_q) begin
                        sus_d[i] = 1'b1;
                     end else begin
                        gate_d[i] = 1'b0;
                     end
                  end
               end
            end
            MSG_CC: begin
               if (msg_note == CC_SUSTAIN) begin
                  sustain_d = msg_value[6];
                  if (!msg_value[6]) begin
                     gate_d = gate_q & ~sus_q;
                     sus_d  = '0;
                  end
               end else if ((msg_note == CC_ALL_SOUND_OFF) || (msg_note == CC_ALL_NOTES_OFF)) begin
                  gate_d = '0;
                  sus_d  = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      voice_note     = '0;
      voice_velocity = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         voice_note[7*i +: 7]     = note_q[i];
         voice_velocity[7*i +: 7] = vel_q[i];
      end
   end

   assign voice_gate    = gate_q;
   assign voice_trigger = trig_q;

endmodule

// File: tb/tb_midi_poly_voice_allocator.sv
// Self-checking bench for midi_poly_voice_allocator: directed vector table,
// hand-written channel-filter sequence, and random bytes against a queue-based model.
module tb_midi_poly_voice_allocator;

   localparam int NV = 4;
   localparam int K_BYTE = 0;
   localparam int K_IDLE = 1;
   localparam int K_RST  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_byte = 8'h00;
   logic [3:0]        midi_channel = 4'd0;
   logic [7*NV-1:0]   voice_note;
   logic [7*NV-1:0]   voice_velocity;
   logic [NV-1:0]     voice_gate;
   logic [NV-1:0]     voice_trigger;

   int checks = 0;
   int errors = 0;

   midi_poly_voice_allocator #(
      .NUM_VOICES(NV),
      .OMNI      (1'b0)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_valid      (rx_valid),
      .rx_byte       (rx_byte),
      .midi_channel  (midi_channel),
      .voice_note    (voice_note),
      .voice_velocity(voice_velocity),
      .voice_gate    (voice_gate),
      .voice_trigger (voice_trigger)
   );

   always #5 clk = ~clk;

   // Reference model: voice arrays plus an allocation-order queue (front = oldest).
   int          mNote [NV];
   int          mVel  [NV];
   bit          mGate [NV];
   bit          mSus  [NV];
   logic [NV-1:0] mTrig;
   int          mOrder[$];
   bit          mSustain;
   int          mStatus;
   int          mCount;
   int          mData1;
   bit          mChanOk;
   bit          mPend;
   int          mPendHi, mPendA, mPendB;

   function automatic void modelReset();
      mOrder.delete();
      for (int i = 0; i < NV; i++) begin
         mNote[i] = 0;
         mVel[i]  = 0;
         mGate[i] = 1'b0;
         mSus[i]  = 1'b0;
         mOrder.push_back(i);
      end
      mTrig    = '0;
      mSustain = 1'b0;
      mStatus  = -1;
      mCount   = 0;
      mData1   = 0;
      mChanOk  = 1'b0;
      mPend    = 1'b0;
   endfunction

   function automatic void modelTouch(int v);
      for (int k = 0; k < mOrder.size(); k++) begin
         if (mOrder[k] == v) begin
            mOrder.delete(k);
            break;
         end
      end
      mOrder.push_back(v);
   endfunction

   function automatic void modelApply();
      int v;
      if (mPendHi == 9 && mPendB != 0) begin
         v = -1;
         for (int i = 0; i < NV; i++) if (v < 0 && mGate[i] && mNote[i] == mPendA) v = i;
         for (int i = 0; i < NV; i++) if (v < 0 && !mGate[i]) v = i;
         if (v < 0) v = mOrder[0];
         mNote[v] = mPendA;
         mVel[v]  = mPendB;
         mGate[v] = 1'b1;
         mSus[v]  = 1'b0;
         mTrig[v] = 1'b1;
         modelTouch(v);
      end else if (mPendHi == 8 || mPendHi == 9) begin
         for (int i = 0; i < NV; i++) begin
            if (mGate[i] && mNote[i] == mPendA) begin
               if (mSustain) mSus[i] = 1'b1;
               else          mGate[i] = 1'b0;
            end
         end
      end else if (mPendHi == 11) begin
         if (mPendA == 64) begin
            mSustain = (mPendB >= 64);
            if (!mSustain) begin
               for (int i = 0; i < NV; i++) begin
                  if (mSus[i]) mGate[i] = 1'b0;
                  mSus[i] = 1'b0;
               end
            end
         end else if (mPendA == 120 || mPendA == 123) begin
            for (int i = 0; i < NV; i++) begin
               mGate[i] = 1'b0;
               mSus[i]  = 1'b0;
            end
         end
      end
   endfunction

   function automatic void modelByte(int b);
      int need;
      if (b >= 'hF8) return;
      if (b >= 'hF0) begin
         mStatus = -1;
         return;
      end
      if (b >= 'h80) begin
         mStatus = b / 16;
         mCount  = 0;
         mChanOk = ((b % 16) == int'(midi_channel));
         return;
      end
      if (mStatus < 0) return;
      need = (mStatus == 12 || mStatus == 13) ? 1 : 2;
      mCount++;
      if (mCount == 1) mData1 = b;
      if (mCount == need) begin
         mCount = 0;
         if (mChanOk && need == 2) begin
            mPend   = 1'b1;
            mPendHi = mStatus;
            mPendA  = mData1;
            mPendB  = b;
         end
      end
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compareModel();
      logic [7*NV-1:0] en, ev;
      logic [NV-1:0]   eg;
      for (int i = 0; i < NV; i++) begin
         en[7*i +: 7] = 7'(mNote[i]);
         ev[7*i +: 7] = 7'(mVel[i]);
         eg[i]        = mGate[i];
      end
      checkOutput("model_note", 64'(voice_note), 64'(en));
      checkOutput("model_velocity", 64'(voice_velocity), 64'(ev));
      checkOutput("model_gate", 64'(voice_gate), 64'(eg));
      checkOutput("model_trigger", 64'(voice_trigger), 64'(mTrig));
   endtask

   task automatic doReset();
      rx_valid = 1'b0;
      rst_n    = 1'b0;
      modelReset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      compareModel();
   endtask

   task automatic tick(input bit v, input logic [7:0] b);
      rx_valid = v;
      rx_byte  = b;
      @(posedge clk);
      mTrig = '0;
      if (mPend) modelApply();
      mPend = 1'b0;
      if (v) modelByte(int'(b));
      #1;
      rx_valid = 1'b0;
      compareModel();
   endtask

   task automatic applyStimulus(input int kind, input logic [7:0] b);
      if (kind == K_RST)       doReset();
      else if (kind == K_IDLE) tick(1'b0, 8'h00);
      else                     tick(1'b1, b);
   endtask

   typedef struct {
      int         kind;
      logic [7:0] b;
      logic [3:0] gate;
      logic [3:0] trig;
      int         vi;
      logic [6:0] note;
      logic [6:0] vel;
   } vec_t;

   vec_t vecs[$];

   function automatic void addVec(int kind, logic [7:0] b, logic [3:0] g, logic [3:0] t,
                                  int vi, logic [6:0] n, logic [6:0] v);
      vec_t r;
      r.kind = kind; r.b = b; r.gate = g; r.trig = t; r.vi = vi; r.note = n; r.vel = v;
      vecs.push_back(r);
   endfunction

   function automatic logic [7:0] randByte(output bit valid);
      int r;
      int hiSel;
      logic [3:0] his [9];
      logic [6:0] specials [6];
      his = '{4'h8, 4'h9, 4'h9, 4'hB, 4'hB, 4'hC, 4'hD, 4'hA, 4'hE};
      specials = '{7'd0, 7'd64, 7'd120, 7'd123, 7'd127, 7'd7};
      valid = 1'b1;
      r = $urandom_range(0, 99);
      if (r < 10) begin
         hiSel = $urandom_range(0, 8);
         return {his[hiSel], midi_channel ^ 4'($urandom_range(0, 1) * (($urandom_range(0, 3) == 0) ? 1 : 0))};
      end else if (r < 12) begin
         return 8'hF8 + 8'($urandom_range(0, 7));
      end else if (r < 13) begin
         return 8'hF0 + 8'($urandom_range(0, 7));
      end else if (r < 18) begin
         valid = 1'b0;
         return 8'h00;
      end else if (r < 65) begin
         return 8'h3C + 8'($urandom_range(0, 5));
      end else if (r < 85) begin
         return {1'b0, specials[$urandom_range(0, 5)]};
      end
      return 8'($urandom_range(0, 127));
   endfunction

   initial begin
      bit         v;
      logic [7:0] b;

      // Test 1: single note on.
      addVec(K_RST,  8'h00, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h90, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h3C, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h64, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_IDLE, 8'h00, 4'h1, 4'h1, 0, 7'h3C, 7'h64);
      addVec(K_IDLE, 8'h00, 4'h1, 4'h0, 0, 7'h3C, 7'h64);
      // Test 3: real-time byte inside a message stream, then note off.
      addVec(K_RST,  8'h00, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h90, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h3C, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h64, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'hF8, 4'h1, 4'h1, 0, 7'h3C, 7'h64);
      addVec(K_BYTE, 8'h80, 4'h1, 4'h0, 0, 7'h3C, 7'h64);
      addVec(K_BYTE, 8'h3C, 4'h1, 4'h0, 0, 7'h3C, 7'h64);
      addVec(K_BYTE, 8'h00, 4'h1, 4'h0, 0, 7'h3C, 7'h64);
      addVec(K_IDLE, 8'h00, 4'h0, 4'h0, 0, 7'h3C, 7'h64);
      // Test 2: running status fills all voices, fifth note steals voice 0.
      addVec(K_RST,  8'h00, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h90, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h40, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h50, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h41, 4'h1, 4'h1, 0, 7'h40, 7'h50);
      addVec(K_BYTE, 8'h50, 4'h1, 4'h0, 0, 7'h40, 7'h50);
      addVec(K_BYTE, 8'h42, 4'h3, 4'h2, 1, 7'h41, 7'h50);
      addVec(K_BYTE, 8'h50, 4'h3, 4'h0, 1, 7'h41, 7'h50);
      addVec(K_BYTE, 8'h43, 4'h7, 4'h4, 2, 7'h42, 7'h50);
      addVec(K_BYTE, 8'h50, 4'h7, 4'h0, 2, 7'h42, 7'h50);
      addVec(K_BYTE, 8'h44, 4'hF, 4'h8, 3, 7'h43, 7'h50);
      addVec(K_BYTE, 8'h50, 4'hF, 4'h0, 3, 7'h43, 7'h50);
      addVec(K_IDLE, 8'h00, 4'hF, 4'h1, 0, 7'h44, 7'h50);
      addVec(K_IDLE, 8'h00, 4'hF, 4'h0, 0, 7'h44, 7'h50);
      // Test 4: sustain pedal holds a released note until pedal up.
      addVec(K_RST,  8'h00, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'hB0, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h40, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h7F, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h90, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h3C, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h40, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_IDLE, 8'h00, 4'h1, 4'h1, 0, 7'h3C, 7'h40);
      addVec(K_BYTE, 8'h80, 4'h1, 4'h0, 0, 7'h3C, 7'h40);
      addVec(K_BYTE, 8'h3C, 4'h1, 4'h0, 0, 7'h3C, 7'h40);
      addVec(K_BYTE, 8'h00, 4'h1, 4'h0, 0, 7'h3C, 7'h40);
      addVec(K_IDLE, 8'h00, 4'h1, 4'h0, 0, 7'h3C, 7'h40);
      addVec(K_BYTE, 8'hB0, 4'h1, 4'h0, 0, 7'h3C, 7'h40);
      addVec(K_BYTE, 8'h40, 4'h1, 4'h0, 0, 7'h3C, 7'h40);
      addVec(K_BYTE, 8'h00, 4'h1, 4'h0, 0, 7'h3C, 7'h40);
      addVec(K_IDLE, 8'h00, 4'h0, 4'h0, 0, 7'h3C, 7'h40);
      // Test 6: reset in the middle of a message clears status and voices.
      addVec(K_RST,  8'h00, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h90, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h3C, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h40, 4'h0, 4'h0, 0, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h3D, 4'h1, 4'h1, 0, 7'h3C, 7'h40);
      addVec(K_BYTE, 8'h40, 4'h1, 4'h0, 0, 7'h3C, 7'h40);
      addVec(K_BYTE, 8'h3E, 4'h3, 4'h2, 1, 7'h3D, 7'h40);
      addVec(K_BYTE, 8'h40, 4'h3, 4'h0, 1, 7'h3D, 7'h40);
      addVec(K_IDLE, 8'h00, 4'h7, 4'h4, 2, 7'h3E, 7'h40);
      addVec(K_BYTE, 8'h90, 4'h7, 4'h0, 2, 7'h3E, 7'h40);
      addVec(K_BYTE, 8'h3C, 4'h7, 4'h0, 2, 7'h3E, 7'h40);
      addVec(K_RST,  8'h00, 4'h0, 4'h0, 2, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h3D, 4'h0, 4'h0, 2, 7'h00, 7'h00);
      addVec(K_BYTE, 8'h40, 4'h0, 4'h0, 2, 7'h00, 7'h00);
      addVec(K_IDLE, 8'h00, 4'h0, 4'h0, 2, 7'h00, 7'h00);
      addVec(K_IDLE, 8'h00, 4'h0, 4'h0, 0, 7'h00, 7'h00);

      modelReset();
      $display("[TB] directed vectors: %0d", vecs.size());
      for (int k = 0; k < vecs.size(); k++) begin
         applyStimulus(vecs[k].kind, vecs[k].b);
         checkOutput($sformatf("vec%0d_gate", k), 64'(voice_gate), 64'(vecs[k].gate));
         checkOutput($sformatf("vec%0d_trigger", k), 64'(voice_trigger), 64'(vecs[k].trig));
         checkOutput($sformatf("vec%0d_note", k), 64'(voice_note[7*vecs[k].vi +: 7]), 64'(vecs[k].note));
         checkOutput($sformatf("vec%0d_velocity", k), 64'(voice_velocity[7*vecs[k].vi +: 7]), 64'(vecs[k].vel));
      end

      // Test 5: channel filter with midi_channel = 2.
      $display("[TB] channel filter sequence");
      midi_channel = 4'd2;
      doReset();
      tick(1'b1, 8'h91); tick(1'b1, 8'h3C); tick(1'b1, 8'h40);
      tick(1'b0, 8'h00); tick(1'b0, 8'h00);
      checkOutput("chan_mismatch_gate", 64'(voice_gate), 64'h0);
      checkOutput("chan_mismatch_trigger", 64'(voice_trigger), 64'h0);
      tick(1'b1, 8'h92); tick(1'b1, 8'h3C); tick(1'b1, 8'h40);
      tick(1'b0, 8'h00);
      checkOutput("chan_match_gate", 64'(voice_gate), 64'h1);
      checkOutput("chan_match_trigger", 64'(voice_trigger), 64'h1);
      checkOutput("chan_match_note", 64'(voice_note[6:0]), 64'h3C);
      checkOutput("chan_match_velocity", 64'(voice_velocity[6:0]), 64'h40);

      // Random byte stream against the model.
      $display("[TB] random stream");
      midi_channel = 4'($urandom_range(0, 15));
      doReset();
      for (int n = 0; n < 4000; n++) begin
         b = randByte(v);
         tick(v, b);
         if (n == 2000) doReset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
